present_decrypt_iter: RTL and testbench
=======================================

// Module: present_decrypt_iter
// PURPOSE
//  Iterative PRESENT-80 decryption core; inverse of the 31-round encryption datapath.
//  Accepts one 64-bit ciphertext and one 80-bit key per start pulse and returns the plaintext.
//  Uses one shared inverse round (inverse P-layer, inverse S-box, round-key XOR).
//  Expands the key forward to K32 on chip, then unrolls the schedule backwards round by round.
// PARAMETERS
//  NROUNDS  31  full rounds; round counter values run 1..NROUNDS; must fit in 5 bits
// PORTS
//  clk    in   1   rising-edge clock; single clock domain
//  reset  in   1   asynchronous, active-high; clears all state
//  start  in   1   request; sampled only when FSM in IDLE
//  key0   in   80  cipher key K1; sampled on the edge that accepts start
//  cdat   in   64  ciphertext; sampled on the edge that accepts start
//  busy   out  1   high while an operation is in progress
//  done   out  1   one-cycle pulse; odat valid from this cycle
//  odat   out  64  plaintext; holds until the next done
// BEHAVIOUR
//  - Reset values: busy=0, done=0, odat=64'h0, FSM=IDLE, cnt=0, key/state regs=0.
//  - FSM states:
//      IDLE -> KEYX on start.
//      KEYX -> WHIT after NROUNDS cycles.
//      WHIT -> DEC after 1 cycle.
//      DEC  -> IDLE after NROUNDS cycles.
//  - Start accepted (edge E0): kreg<=key0, sreg<=cdat, cnt<=1, busy<=1.
//  - KEYX, forward key update, one per cycle, with i=cnt:
//      k = {k[18:0], k[79:19]};
//      k[79:76] = S(k[79:76]);
//      k[19:15] ^= i[4:0];
//      cnt++.
//    After NROUNDS cycles kreg=K32.
//  - WHIT: sreg ^= kreg[79:16]; cnt<=NROUNDS.
//  - DEC, one per cycle, with i=cnt:
//      sreg = invS(invP(sreg)) per nibble;
//      k[19:15] ^= i;
//      k[79:76] = invS(k[79:76]);
//      k = {k[60:0], k[79:61]}   (yields K_i);
//      sreg ^= K_i[79:16];
//      cnt--.
//    All of this is combinational within the cycle; one register stage per round.
//  - invP: bit j -> bit (j*4 mod 63), bit 63 fixed (the inverse of the 16*j mod 63 P-layer).
//  - invS table (in 0..F): 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
//  - Completion: on the edge that finishes the final DEC round (E63), odat<=result, done<=1,
//    busy<=0, FSM<=IDLE.
//  - Latency: done is high in the cycle after E63, i.e. 2*NROUNDS+1 clocks after start is sampled.
//  - start while busy=1: ignored, no queueing. key0/cdat changes while busy: no effect.
//  - start high in the done cycle: accepted, because the FSM is already IDLE.
//    done still pulses exactly once for the prior operation.
//  - start held high continuously: back-to-back operations, one per 2*NROUNDS+2 cycles.
//  - Reset mid-operation: abort immediately, no done. odat returns to 0.
//  - cnt is 5 bits. XOR uses cnt[4:0] exactly; no wrap occurs for NROUNDS<=31.
// TESTING
//  - T1: key0=80'h0, cdat=64'h5579C1387B228445 -> odat=64'h0000000000000000,
//    done exactly 63 cycles after start.
//  - T2: key0=80'hFFFF_FFFFFFFF_FFFFFFFF, cdat=64'hE72C46C0F5945049 -> odat=64'h0.
//  - T3: key0=80'h0, cdat=64'hA112FFC72F68417B -> odat=64'hFFFFFFFFFFFFFFFF.
//  - T4: key0=80'hFFFF_FFFFFFFF_FFFFFFFF, cdat=64'h3333DCD3213210D2 -> odat=64'hFFFFFFFFFFFFFFFF.
//    Pulse start at cycle 10 of the op -> ignored, single done.
//  - T5: assert reset at cycle 30 of the T1 op -> busy=0, done=0, odat=0.
//    Then rerun T1 -> correct result.
//  - T6: back-to-back T1 then T3 with start held high -> two done pulses 64 cycles apart,
//    with correct odat values in order.

Source files
------------

// File: rtl/present_decrypt_iter.sv
// present_decrypt_iter: iterative PRESENT-80 decryption core.
// One ciphertext/key pair is taken per accepted start. The key is first run
// forward to K32, the ciphertext is whitened with K32, then one shared inverse
// round per cycle peels off rounds 31..1 while the key schedule is unrolled
// backwards.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   start  operation request, sampled only in IDLE
//   key0   80-bit cipher key, captured with start
//   cdat   64-bit ciphertext, captured with start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when odat is updated
//   odat   64-bit plaintext, held until the next done
module present_decrypt_iter #(
  parameter int unsigned NROUNDS = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [79:0] key0,
  input  logic [63:0] cdat,
  output logic        busy,
  output logic        done,
  output logic [63:0] odat
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST = CW'(NROUNDS);

  typedef enum logic [1:0] {IDLE, KEYX, WHIT, DEC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [79:0]   kreg;
  logic [63:0]   sreg;

  logic [79:0]   key_fwd;
  logic [79:0]   key_bwd;
  logic [63:0]   s_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  // Inverse permutation: bit j moves to bit 4*j mod 63, bit 63 stays put.
  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) begin
      y[6'((j * 4) % 63)] = x[6'(j)];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Forward key update for round cnt (used during KEYX).
  always_comb begin
    key_fwd = {kreg[18:0], kreg[79:19]};
    key_fwd[79:76] = sbox(key_fwd[79:76]);
    key_fwd[19:15] = key_fwd[19:15] ^ cnt;
  end

  // One inverse round: invP, invS, then XOR with K_cnt recovered from K_(cnt+1).
  always_comb begin
    logic [63:0] p;
    logic [79:0] k;
    p = inv_player(sreg);
    s_nxt = '0;
    for (int n = 0; n < 16; n++) begin
      s_nxt[6'(n * 4) +: 4] = inv_sbox(p[6'(n * 4) +: 4]);
    end
    k = kreg;
    k[19:15] = k[19:15] ^ cnt;
    k[79:76] = inv_sbox(k[79:76]);
    key_bwd = {k[60:0], k[79:61]};
    s_nxt = s_nxt ^ key_bwd[79:16];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      kreg  <= '0;
      sreg  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      odat  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kreg  <= key0;
            sreg  <= cdat;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= KEYX;
          end
        end
        KEYX: begin
          kreg <= key_fwd;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= WHIT;
        end
        WHIT: begin
          sreg  <= sreg ^ kreg[79:16];
          cnt   <= LAST;
          state <= DEC;
        end
        DEC: begin
          sreg <= s_nxt;
          kreg <= key_bwd;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            odat  <= s_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_decrypt_iter.sv
// Testbench for present_decrypt_iter: known-answer vectors, protocol corner
// cases (start while busy, reset mid-operation, back-to-back starts) and random
// key/plaintext pairs encrypted by a forward PRESENT-80 model in the bench.
module tb_present_decrypt_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] key0;
  logic [63:0] cdat;
  logic        busy;
  logic        done;
  logic [63:0] odat;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  localparam logic [79:0] K_ZERO = 80'h0;
  localparam logic [79:0] K_ONES = 80'hFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [63:0] C1 = 64'h5579C1387B228445;
  localparam logic [63:0] C2 = 64'hE72C46C0F5945049;
  localparam logic [63:0] C3 = 64'hA112FFC72F68417B;
  localparam logic [63:0] C4 = 64'h3333DCD3213210D2;

  present_decrypt_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key0  (key0),
    .cdat  (cdat),
    .busy  (busy),
    .done  (done),
    .odat  (odat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // Forward PRESENT-80 encryption, straight from the cipher definition.
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] encrypt(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[6'(n * 4) +: 4] = SB[s[6'(n * 4) +: 4]];
      for (int j = 0; j < 63; j++) s[6'((j * 16) % 63)] = t[6'(j)];
      s[63] = t[63];
      k = (k << 61) | (k >> 19);
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one operation; optionally pulse start (with garbage inputs) at cycle glitch_at.
  task automatic run_op(input logic [79:0] k, input logic [63:0] c, input int glitch_at,
                        output int lat, output logic [63:0] res);
    key0  = k;
    cdat  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
      if (lat == 5) chk("busy_mid_op", 64'(busy), 64'd1);
      if (lat == glitch_at) begin
        start = 1'b1;
        cdat  = ~cdat;
        key0  = ~key0;
      end else begin
        start = 1'b0;
      end
    end
    res = odat;
  endtask

  task automatic op_check(input string tag, input logic [79:0] k, input logic [63:0] c,
                          input logic [63:0] exp, input int glitch_at);
    int lat;
    logic [63:0] res;
    run_op(k, c, glitch_at, lat, res);
    chk({tag, "_latency"}, 64'(lat), 64'd63);
    chk({tag, "_odat"}, res, exp);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_odat_hold"}, odat, exp);
  endtask

  initial begin
    int n;
    int d0;
    logic [79:0] rk;
    logic [63:0] rp;

    reset = 1'b1;
    start = 1'b0;
    key0  = '0;
    cdat  = '0;
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_odat", odat, 64'h0);
    reset = 1'b0;
    tick();

    op_check("t1", K_ZERO, C1, 64'h0, 0);
    op_check("t2", K_ONES, C2, 64'h0, 0);
    op_check("t3", K_ZERO, C3, 64'hFFFFFFFFFFFFFFFF, 0);

    d0 = done_cnt;
    op_check("t4", K_ONES, C4, 64'hFFFFFFFFFFFFFFFF, 10);
    repeat (80) tick();
    chk("t4_single_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of an operation.
    key0  = K_ZERO;
    cdat  = C1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_odat", odat, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    op_check("t5_rerun", K_ZERO, C1, 64'h0, 0);

    // Back-to-back with start held high.
    key0  = K_ZERO;
    cdat  = C1;
    start = 1'b1;
    tick();
    cdat = C3;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("t6_first_latency", 64'(n), 64'd63);
    chk("t6_first_odat", odat, 64'h0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
    start = 1'b0;
    chk("t6_spacing", 64'(n), 64'd64);
    chk("t6_second_odat", odat, 64'hFFFFFFFFFFFFFFFF);
    repeat (70) tick();
    chk("t6_idle_after", 64'(busy), 64'd0);

    // Random keys and plaintexts through the forward model.
    for (int r = 0; r < 8; r++) begin
      rk = {16'($urandom), $urandom, $urandom};
      rp = {$urandom, $urandom};
      op_check("rand", rk, encrypt(rk, rp), rp, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
